// File: rtl/qcw_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qcw_gate_pkg
// Description : Shared leg-state encoding and default sizes for the QCW gate
//               drive output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package qcw_gate_pkg;

    localparam int c_def_num_ch   = 2;
    localparam int c_def_dt_width = 8;
    localparam int c_def_min_on   = 4;

    typedef enum logic [2:0] {
        LEG_OFF  = 3'd0,
        LEG_P_DT = 3'd1,
        LEG_P_ON = 3'd2,
        LEG_N_DT = 3'd3,
        LEG_N_ON = 3'd4
    } leg_state_t;

endpackage
`default_nettype wire

// File: rtl/qcw_gate_drive_if.sv
`default_nettype none
// ============================================================================
// Module      : qcw_gate_drive_if
// Description : Command/status bundle between the PLL-side controller (master)
//               and the gate drive output stage (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface qcw_gate_drive_if #(
    parameter int NUM_CH   = 2,
    parameter int DT_WIDTH = 8
);
    logic                enable;
    logic [NUM_CH-1:0]   phase_in;
    logic [DT_WIDTH-1:0] deadtime;
    logic                fault_in;
    logic                fault_clear;
    logic [NUM_CH-1:0]   gate_p;
    logic [NUM_CH-1:0]   gate_n;
    logic                active;
    logic                fault_latched;

    modport master (
        output enable, phase_in, deadtime, fault_in, fault_clear,
        input  gate_p, gate_n, active, fault_latched
    );

    modport slave (
        input  enable, phase_in, deadtime, fault_in, fault_clear,
        output gate_p, gate_n, active, fault_latched
    );
endinterface
`default_nettype wire

// File: rtl/qcw_gate_leg.sv
`default_nettype none
// ============================================================================
// Module      : qcw_gate_leg
// Description : One half-bridge leg: dead-time FSM producing a registered
//               complementary P/N gate pair. QCW_GATE_MIN_PULSE_EN adds an
//               on-time counter enforcing MIN_ON.
// Revision    : 1.0 - initial release
// ============================================================================
module qcw_gate_leg
    import qcw_gate_pkg::*;
#(
    parameter int DT_WIDTH = c_def_dt_width
`ifdef QCW_GATE_MIN_PULSE_EN
    ,
    parameter int MIN_ON   = c_def_min_on
`endif
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                i_run,
    input  wire logic                i_phase,
    input  wire logic [DT_WIDTH-1:0] i_deadtime,
    output logic                     o_gate_p,
    output logic                     o_gate_n,
    output logic                     o_active
);

    localparam logic [DT_WIDTH-1:0] c_dt_one = DT_WIDTH'(1);

    leg_state_t          r_state;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic                r_gate_p;
    logic                r_gate_n;
    logic                r_active;
    logic [DT_WIDTH-1:0] w_dt_load;
    logic                w_on_done;

    // A zero dead time still yields one both-off cycle.
    assign w_dt_load = (i_deadtime == '0) ? c_dt_one : i_deadtime;

`ifdef QCW_GATE_MIN_PULSE_EN
    localparam int c_on_w = $clog2(MIN_ON + 1);

    logic [c_on_w-1:0] r_on_cnt;
    logic              w_enter_on;

    assign w_enter_on = i_run && (r_dt_cnt == c_dt_one) &&
                        (((r_state == LEG_P_DT) &&  i_phase) ||
                         ((r_state == LEG_N_DT) && !i_phase));
    assign w_on_done  = (r_on_cnt <= c_on_w'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_on_cnt <= '0;
        end else if (w_enter_on) begin
            r_on_cnt <= c_on_w'(MIN_ON);
        end else if (r_on_cnt > c_on_w'(1)) begin
            r_on_cnt <= r_on_cnt - c_on_w'(1);
        end
    end
`else
    assign w_on_done = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= LEG_OFF;
            r_dt_cnt <= '0;
            r_gate_p <= 1'b0;
            r_gate_n <= 1'b0;
            r_active <= 1'b0;
        end else if (!i_run) begin
            r_state  <= LEG_OFF;
            r_gate_p <= 1'b0;
            r_gate_n <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                LEG_OFF: begin
                    r_state  <= i_phase ? LEG_P_DT : LEG_N_DT;
                    r_dt_cnt <= w_dt_load;
                end
                LEG_P_DT: begin
                    if (!i_phase) begin
                        r_state  <= LEG_N_DT;
                        r_dt_cnt <= w_dt_load;
                    end else if (r_dt_cnt == c_dt_one) begin
                        r_state  <= LEG_P_ON;
                        r_gate_p <= 1'b1;
                    end else begin
                        r_dt_cnt <= r_dt_cnt - c_dt_one;
                    end
                end
                LEG_N_DT: begin
                    if (i_phase) begin
                        r_state  <= LEG_P_DT;
                        r_dt_cnt <= w_dt_load;
                    end else if (r_dt_cnt == c_dt_one) begin
                        r_state  <= LEG_N_ON;
                        r_gate_n <= 1'b1;
                    end else begin
                        r_dt_cnt <= r_dt_cnt - c_dt_one;
                    end
                end
                LEG_P_ON: begin
                    if (!i_phase && w_on_done) begin
                        r_state  <= LEG_N_DT;
                        r_dt_cnt <= w_dt_load;
                        r_gate_p <= 1'b0;
                    end
                end
                LEG_N_ON: begin
                    if (i_phase && w_on_done) begin
                        r_state  <= LEG_P_DT;
                        r_dt_cnt <= w_dt_load;
                        r_gate_n <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= LEG_OFF;
                    r_gate_p <= 1'b0;
                    r_gate_n <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_gate_p = r_gate_p;
    assign o_gate_n = r_gate_n;
    assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/qcw_gate_drive.sv
`default_nettype none
// ============================================================================
// Module      : qcw_gate_drive
// Description : Bridge gate-drive output stage: run qualification, sticky
//               fault latch and NUM_CH dead-time legs. Optional minimum gate
//               on-time via QCW_GATE_MIN_PULSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qcw_gate_drive
    import qcw_gate_pkg::*;
#(
    parameter int NUM_CH   = c_def_num_ch,
    parameter int DT_WIDTH = c_def_dt_width
`ifdef QCW_GATE_MIN_PULSE_EN
    ,
    parameter int MIN_ON   = c_def_min_on
`endif
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    qcw_gate_drive_if.slave gd
);

    logic              r_fault;
    logic              w_run;
    logic [NUM_CH-1:0] w_gate_p;
    logic [NUM_CH-1:0] w_gate_n;
    logic [NUM_CH-1:0] w_leg_active;

    // The live fault level blocks run too, so gates drop on the same edge
    // that sets the latch.
    assign w_run = gd.enable && !r_fault && !gd.fault_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault <= 1'b0;
        end else if (gd.fault_in) begin
            r_fault <= 1'b1;
        end else if (gd.fault_clear) begin
            r_fault <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_leg
        qcw_gate_leg #(
            .DT_WIDTH (DT_WIDTH)
`ifdef QCW_GATE_MIN_PULSE_EN
            ,
            .MIN_ON   (MIN_ON)
`endif
        ) u_leg (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_run      (w_run),
            .i_phase    (gd.phase_in[g]),
            .i_deadtime (gd.deadtime),
            .o_gate_p   (w_gate_p[g]),
            .o_gate_n   (w_gate_n[g]),
            .o_active   (w_leg_active[g])
        );
    end

    assign gd.gate_p        = w_gate_p;
    assign gd.gate_n        = w_gate_n;
    assign gd.active        = |w_leg_active;
    assign gd.fault_latched = r_fault;

endmodule
`default_nettype wire
